decode_2_4_pipe: RTL and testbench



---
 rtl/decode_2_4_pipe.sv | 101 ++++++++++
 tb/tb_decode_2_4_pipe.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/decode_2_4_pipe.sv
// rtl/decode_2_4_pipe.sv - pipelined 2-to-4 decoder with 2-entry output FIFO and idle-word counter
//
// Expands {V,Y} code words from the 4x2 encoder back to one-hot vectors.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   upstream code word valid
//   in_ready   out  block can accept a word this cycle
//   V          in   encoder valid flag of the code word
//   Y[1:0]     in   encoder index of the code word
//   out_valid  out  FIFO head valid
//   out_ready  in   downstream consumes head this cycle
//   out_V      out  V of head word
//   D[3:0]     out  one-hot decode of head word
//   idle_cnt   out  saturating count of accepted V=0 words
module decode_2_4_pipe #(
  parameter int CNT_W      = 8,
  parameter bit STORE_IDLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             V,
  input  logic [1:0]       Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_V,
  output logic [3:0]       D,
  output logic [CNT_W-1:0] idle_cnt
);

  logic [1:0]       r_count;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [4:0]       r_mem [2];
  logic [CNT_W-1:0] r_idle_cnt;

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [3:0]       w_dec;

  // Ready depends only on registered occupancy, never on out_ready, so a
  // full FIFO cannot pass a word through in the same cycle.
  assign in_ready  = rst_n && (r_count < 2'd2);
  assign w_accept  = in_valid && in_ready;
  // Idle words are always consumed, but only stored when STORE_IDLE is set.
  assign w_push    = w_accept && (V || STORE_IDLE);
  assign out_valid = (r_count != 2'd0);
  assign w_pop     = out_valid && out_ready;

  // V gates the decode first so that Y is fully don't-care for idle words.
  always_comb begin
    w_dec = 4'b0000;
    if (V) begin
      case (Y)
        2'd0:    w_dec = 4'b0001;
        2'd1:    w_dec = 4'b0010;
        2'd2:    w_dec = 4'b0100;
        default: w_dec = 4'b1000;
      endcase
    end
  end

  always_comb begin
    out_V = 1'b0;
    D     = 4'b0000;
    if (r_count != 2'd0) begin
      {out_V, D} = r_mem[r_rd_ptr];
    end
  end

  assign idle_cnt = r_idle_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count    <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {V, w_dec};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_accept && !V && (r_idle_cnt != {CNT_W{1'b1}})) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_2_4_pipe.sv
// tb/tb_decode_2_4_pipe.sv - directed self-checking bench for decode_2_4_pipe
module tb_decode_2_4_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       V;
  logic [1:0] Y;
  logic       out_ready;

  // default instance: CNT_W=8, STORE_IDLE=1
  logic       a_in_ready, a_out_valid, a_out_V;
  logic [3:0] a_D;
  logic [7:0] a_idle_cnt;
  // STORE_IDLE=0 instance
  logic       b_in_ready, b_out_valid, b_out_V;
  logic [3:0] b_D;
  logic [7:0] b_idle_cnt;
  // CNT_W=2 instance
  logic       c_in_ready, c_out_valid, c_out_V;
  logic [3:0] c_D;
  logic [1:0] c_idle_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decode_2_4_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .V(V), .Y(Y), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_V(a_out_V), .D(a_D), .idle_cnt(a_idle_cnt)
  );

  decode_2_4_pipe #(.CNT_W(8), .STORE_IDLE(1'b0)) dut_ni (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .V(V), .Y(Y), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_V(b_out_V), .D(b_D), .idle_cnt(b_idle_cnt)
  );

  decode_2_4_pipe #(.CNT_W(2), .STORE_IDLE(1'b1)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .V(V), .Y(Y), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_V(c_out_V), .D(c_D), .idle_cnt(c_idle_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_d [4];
    logic [1:0] exp_sat [5];
    exp_d   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // reset held 3 cycles with a word offered
    rst_n = 1'b0; in_valid = 1'b1; V = 1'b1; Y = 2'd1; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready",  a_in_ready,  0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_V",     a_out_V,     0);
    check("rst_D",         a_D,         0);
    check("rst_idle",      a_idle_cnt,  0);
    check("rst_idle_c2",   c_idle_cnt,  0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    check("rel_in_ready", a_in_ready, 1);
    tick();
    check("rel_out_valid", a_out_valid, 0);

    // decode sweep, back-to-back with out_ready high
    out_ready = 1'b1; in_valid = 1'b1; V = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Y = 2'(i);
      tick();
      check($sformatf("sweep_valid%0d", i), a_out_valid, 1);
      check($sformatf("sweep_V%0d", i),     a_out_V,     1);
      check($sformatf("sweep_D%0d", i),     a_D,         exp_d[i]);
      check($sformatf("sweep_ni_D%0d", i),  b_D,         exp_d[i]);
    end
    in_valid = 1'b0;
    tick();
    check("sweep_drain", a_out_valid, 0);

    // backpressure: Y=2,0,3 with out_ready low
    out_ready = 1'b0; in_valid = 1'b1; V = 1'b1; Y = 2'd2;
    tick();
    check("bp_D_first", a_D, 4'b0100);
    Y = 2'd0;
    check("bp_ready_1", a_in_ready, 1);
    tick();
    check("bp_full_ready", a_in_ready, 0);
    check("bp_head_hold1", a_D, 4'b0100);
    Y = 2'd3;
    tick();
    check("bp_third_blocked", a_in_ready, 0);
    check("bp_head_hold2", a_D, 4'b0100);
    check("bp_valid", a_out_valid, 1);
    out_ready = 1'b1;
    #1;
    check("bp_no_passthru", a_in_ready, 0);
    tick();
    check("bp_pop1_D", a_D, 4'b0001);
    check("bp_pop1_ready", a_in_ready, 1);
    tick();
    check("bp_third_D", a_D, 4'b1000);
    in_valid = 1'b0;
    tick();
    check("bp_drain", a_out_valid, 0);

    // idle word {V,Y}=011
    in_valid = 1'b1; V = 1'b0; Y = 2'd3;
    tick();
    check("idle_valid", a_out_valid, 1);
    check("idle_V",     a_out_V,     0);
    check("idle_D",     a_D,         0);
    check("idle_cnt",   a_idle_cnt,  1);
    check("idle_ni_valid", b_out_valid, 0);
    check("idle_ni_cnt",   b_idle_cnt,  1);
    Y = 2'bxx;
    tick();
    check("idle_x_D",   a_D,        0);
    check("idle_x_cnt", a_idle_cnt, 2);
    in_valid = 1'b0;
    tick();
    check("idle_drain", a_out_valid, 0);

    // mid-stream reset with FIFO full
    out_ready = 1'b0; in_valid = 1'b1; V = 1'b1; Y = 2'd1;
    tick();
    Y = 2'd2;
    tick();
    check("mid_full", a_in_ready, 0);
    rst_n = 1'b0;
    tick();
    check("mid_out_valid", a_out_valid, 0);
    check("mid_idle",      a_idle_cnt,  0);
    check("mid_in_ready",  a_in_ready,  0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("mid_no_stale", a_out_valid, 0);
    check("mid_ready",    a_in_ready,  1);

    // saturation on the CNT_W=2 instance
    in_valid = 1'b1; V = 1'b0; Y = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat_c2_%0d", i), c_idle_cnt, exp_sat[i]);
      check($sformatf("sat_a_%0d", i),  a_idle_cnt, 32'(i + 1));
    end
    in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
